// File: rtl/trash_prog_loader.sv
// Host byte-stream to 16-bit instruction-bus packer for the trash core.
// Emits PROG_DEPTH program words (mode bit 0), then unbounded execution words (mode bit 1).
module trash_prog_loader #(
  parameter int unsigned PROG_DEPTH = 8,
  parameter int unsigned CNT_W      = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [7:0]       host_data_i,
  input  logic             host_valid_i,
  output logic             host_ready_o,
  output logic [15:0]      bus_word_o,
  output logic             bus_valid_o,
  output logic             loading_o,
  output logic             done_o,
  output logic [CNT_W-1:0] word_cnt_o
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LD_LO    = 3'd1;
  localparam logic [2:0] LD_HI    = 3'd2;
  localparam logic [2:0] LD_EMIT  = 3'd3;
  localparam logic [2:0] RUN_LO   = 3'd4;
  localparam logic [2:0] RUN_HI   = 3'd5;
  localparam logic [2:0] RUN_EMIT = 3'd6;

  localparam logic [15:0]      NOOP_WORD = 16'h0001;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(PROG_DEPTH - 1);

  logic [2:0]       state_q, state_d;
  logic [6:0]       lo_q, lo_d;
  logic [15:0]      bus_word_q, bus_word_d;
  logic             bus_valid_q, bus_valid_d;
  logic             loading_q, loading_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic             ready_state;
  logic             hs;

  // Ready is a pure state decode, masked while a restart is requested so no byte is taken.
  assign ready_state  = (state_q == LD_LO) || (state_q == LD_HI) ||
                        (state_q == RUN_LO) || (state_q == RUN_HI);
  assign host_ready_o = ready_state && !start_i;
  assign hs           = host_valid_i && host_ready_o;

  assign bus_word_o  = bus_word_q;
  assign bus_valid_o = bus_valid_q;
  assign loading_o   = loading_q;
  assign done_o      = done_q;
  assign word_cnt_o  = word_cnt_q;

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    bus_word_d  = NOOP_WORD;
    bus_valid_d = 1'b0;
    loading_d   = loading_q;
    done_d      = done_q;
    word_cnt_d  = word_cnt_q;

    if (start_i) begin
      state_d    = LD_LO;
      lo_d       = 7'd0;
      loading_d  = 1'b1;
      done_d     = 1'b0;
      word_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: ;
        LD_LO, RUN_LO: begin
          if (hs) begin
            lo_d    = host_data_i[7:1];
            state_d = (state_q == LD_LO) ? LD_HI : RUN_HI;
          end
        end
        LD_HI: begin
          if (hs) begin
            bus_word_d  = {host_data_i, lo_q, 1'b0};
            bus_valid_d = 1'b1;
            state_d     = LD_EMIT;
          end
        end
        RUN_HI: begin
          if (hs) begin
            bus_word_d  = {host_data_i, lo_q, 1'b1};
            bus_valid_d = 1'b1;
            state_d     = RUN_EMIT;
          end
        end
        LD_EMIT: begin
          if (word_cnt_q == LAST_CNT) begin
            word_cnt_d = '0;
            loading_d  = 1'b0;
            done_d     = 1'b1;
            state_d    = RUN_LO;
          end else begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
            state_d    = LD_LO;
          end
        end
        RUN_EMIT: state_d = RUN_LO;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lo_q        <= 7'd0;
      bus_word_q  <= NOOP_WORD;
      bus_valid_q <= 1'b0;
      loading_q   <= 1'b0;
      done_q      <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      bus_word_q  <= bus_word_d;
      bus_valid_q <= bus_valid_d;
      loading_q   <= loading_d;
      done_q      <= done_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

endmodule

// File: tb/tb_trash_prog_loader.sv
// Directed bench for trash_prog_loader: a byte-level phase model checked every cycle,
// plus literal expectations on the words seen on the bus.
module tb_trash_prog_loader;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  host_data = 8'h00;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic [15:0] bus_word;
  logic        bus_valid;
  logic        loading;
  logic        done;
  logic [2:0]  word_cnt;

  int tests = 0;
  int fails = 0;

  trash_prog_loader #(.PROG_DEPTH(DEPTH), .CNT_W(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start),
    .host_data_i  (host_data),
    .host_valid_i (host_valid),
    .host_ready_o (host_ready),
    .bus_word_o   (bus_word),
    .bus_valid_o  (bus_valid),
    .loading_o    (loading),
    .done_o       (done),
    .word_cnt_o   (word_cnt)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: phase 0=idle, 1=load, 2=run; a word is a lo byte then a hi byte,
  // followed by one cycle where the word is shown and no byte is taken.
  int          m_phase = 0;
  bit          m_have_lo = 0;
  bit          m_emit = 0;
  logic [7:0]  m_lo = 8'h00;
  int          m_cnt = 0;
  bit          m_done = 0;
  bit          m_loading = 0;
  logic [15:0] e_word = 16'h0001;
  bit          e_valid = 0;
  bit          chk_en = 0;
  bit          m_ready;

  initial forever begin
    @(posedge clk);
    m_ready = (m_phase != 0) && !m_emit && !start;
    if (reset) begin
      m_phase = 0; m_have_lo = 0; m_emit = 0; m_cnt = 0;
      m_done = 0; m_loading = 0; e_word = 16'h0001; e_valid = 0;
      chk_en = 1;
    end else begin
      e_word  = 16'h0001;
      e_valid = 0;
      if (start) begin
        m_phase = 1; m_have_lo = 0; m_emit = 0;
        m_cnt = 0; m_done = 0; m_loading = 1;
      end else if (m_emit) begin
        m_emit = 0;
        if (m_phase == 1) begin
          m_cnt = m_cnt + 1;
          if (m_cnt == DEPTH) begin
            m_cnt = 0; m_done = 1; m_loading = 0; m_phase = 2;
          end
        end
      end else if (host_valid && m_ready) begin
        if (!m_have_lo) begin
          m_lo = host_data;
          m_have_lo = 1;
        end else begin
          e_word  = {host_data, m_lo[7:1], (m_phase == 2) ? 1'b1 : 1'b0};
          e_valid = 1;
          m_emit  = 1;
          m_have_lo = 0;
        end
      end
    end
  end

  logic [15:0] seen[$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("bus_word", 32'(bus_word), 32'(e_word));
      check("bus_valid", 32'(bus_valid), 32'(e_valid));
      check("loading", 32'(loading), 32'(m_loading));
      check("done", 32'(done), 32'(m_done));
      check("word_cnt", 32'(word_cnt), 32'(m_cnt));
      check("host_ready", 32'(host_ready),
            32'((m_phase != 0) && !m_emit && !start));
      if (bus_valid) seen.push_back(bus_word);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    host_data  = b;
    host_valid = 1'b1;
    @(negedge clk);
    while (!host_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!host_ready) begin
      tests++;
      fails++;
      $display("FAIL handshake_timeout actual=no_ready required=ready byte=%h", b);
    end
    @(posedge clk);
    #1 host_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] lo, input logic [7:0] hi);
    send_byte(lo);
    send_byte(hi);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  function automatic logic [15:0] seen_at(input int i);
    if (i < seen.size()) return seen[i];
    return 16'hxxxx;
  endfunction

  initial begin
    // T1: reset with host_valid high
    host_valid = 1'b1;
    host_data  = 8'hA5;
    #1;
    repeat (2) @(posedge clk);
    #1;
    check("t1_bus_word", 32'(bus_word), 32'h0001);
    check("t1_bus_valid", 32'(bus_valid), 32'h0);
    check("t1_host_ready", 32'(host_ready), 32'h0);
    check("t1_done", 32'(done), 32'h0);
    check("t1_word_cnt", 32'(word_cnt), 32'h0);
    reset = 1'b0;
    host_valid = 1'b0;
    idle(2);
    check("idle_host_ready", 32'(host_ready), 32'h0);

    // T2: full program load
    pulse_start();
    check("t2_loading", 32'(loading), 32'h1);
    seen.delete();
    for (int i = 0; i < 8; i++) begin
      send_word(8'h03, 8'h12);
      check("t2_pulse_after_hi", 32'(bus_valid), 32'h1);
    end
    idle(1);
    check("t2_done", 32'(done), 32'h1);
    check("t2_loading_off", 32'(loading), 32'h0);
    check("t2_word_cnt", 32'(word_cnt), 32'h0);
    check("t2_n_words", 32'(seen.size()), 32'd8);
    for (int i = 0; i < 8; i++) check("t2_word", 32'(seen_at(i)), 32'h1202);

    // T3: first execution word
    seen.delete();
    send_word(8'h13, 8'h2A);
    idle(1);
    check("t3_n_words", 32'(seen.size()), 32'd1);
    check("t3_word", 32'(seen_at(0)), 32'h2A13);
    check("t3_word_cnt", 32'(word_cnt), 32'h0);

    // T4: host stall between lo and hi
    pulse_start();
    seen.delete();
    send_byte(8'h10);
    idle(5);
    check("t4_no_word_in_stall", 32'(seen.size()), 32'd0);
    send_byte(8'h55);
    idle(1);
    check("t4_word", 32'(seen_at(0)), 32'h5510);
    check("t4_word_cnt", 32'(word_cnt), 32'h1);

    // T5: restart drops latched lo and a byte offered alongside start
    send_byte(8'hFF);
    host_data  = 8'hAA;
    host_valid = 1'b1;
    pulse_start();
    host_valid = 1'b0;
    check("t5_word_cnt", 32'(word_cnt), 32'h0);
    seen.delete();
    send_word(8'h04, 8'h01);
    idle(1);
    check("t5_word", 32'(seen_at(0)), 32'h0104);
    check("t5_word_cnt_after", 32'(word_cnt), 32'h1);

    // T6: restart during a shown word, then reset mid-load
    pulse_start();
    seen.delete();
    for (int i = 0; i < 3; i++) send_word(8'h21, 8'h30);
    idle(1);
    check("t6_word_cnt3", 32'(word_cnt), 32'h3);
    send_word(8'h41, 8'h50);
    pulse_start();
    check("t6_restart_cnt", 32'(word_cnt), 32'h0);
    check("t6_emit_completes", 32'(seen.size()), 32'd4);
    check("t6_last_word", 32'(seen_at(3)), 32'h5040);
    send_byte(8'h66);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("t6_rst_bus_word", 32'(bus_word), 32'h0001);
    check("t6_rst_loading", 32'(loading), 32'h0);
    check("t6_rst_word_cnt", 32'(word_cnt), 32'h0);
    check("t6_rst_host_ready", 32'(host_ready), 32'h0);
    pulse_start();
    seen.delete();
    for (int i = 0; i < 8; i++) send_word(8'(2 * i + 1), 8'(8'hE0 + i));
    idle(1);
    check("t6_reload_done", 32'(done), 32'h1);
    check("t6_reload_n", 32'(seen.size()), 32'd8);
    check("t6_reload_w5", 32'(seen_at(5)), 32'hE50A);
    seen.delete();
    send_word(8'h80, 8'hC3);
    idle(1);
    check("t6_run_word", 32'(seen_at(0)), 32'hC381);

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
